// File: rtl/heroe_pkg.sv
// heroe_pkg: shared game-state codes, scroller FSM encoding, segment masks and spawn codes.
package heroe_pkg;
  typedef enum logic [2:0] {OFF = 3'd0, WLCM = 3'd1, CH = 3'd2, GAME = 3'd3, WL = 3'd4, PA = 3'd5} game_st_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HIT = 2'd2} scr_st_e;
  localparam logic [6:0] SEG_TOP = 7'b0000001;
  localparam logic [6:0] SEG_BOT = 7'b0001000;
  localparam logic [1:0] SPAWN_TOP = 2'b01;
  localparam logic [1:0] SPAWN_BOT = 2'b10;
  function automatic logic [6:0] slot_seg(input logic t, input logic b);
    return (t ? SEG_TOP : 7'd0) | (b ? SEG_BOT : 7'd0);
  endfunction
endpackage

// File: rtl/obstacle_scroller_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifts left with feedback into bit0.
//   clk, rst_n (async, active-low, loads SEED), en (advance one step), q[7:0] (state)
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);
  logic [7:0] q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= SEED;
    else if (en) q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  assign q = q_q;
endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: two-lane scrolling obstacle field with collision detection and score.
//   clk, rst_n (async active-low), presente[2:0] (game state), hero_lane (0=top, 1=bottom)
//   display_obs[20:0] (far digit [20:14] .. hero-side digit [6:0]), hit (pulse), game_over, score
//   Optional OBS_SPEEDUP_EN: scroll period shrinks by DIV_STEP every 8 clears, floored at MIN_DIV.
module obstacle_scroller
  import heroe_pkg::*;
#(
  parameter logic [26:0] TICK_DIV  = 27'd6_000_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int          SCORE_W   = 8,
  parameter logic [26:0] MIN_DIV   = 27'd1_500_000,
  parameter logic [26:0] DIV_STEP  = 27'd500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         presente,
  input  logic               hero_lane,
  output logic [20:0]        display_obs,
  output logic               hit,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);
  scr_st_e            state_q, state_d;
  logic [26:0]        cnt_q, cnt_d, period;
  logic [2:0]         top_q, top_d, bot_q, bot_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               go_q, go_d, hit_q, hit_d, tick, inc;
  logic [20:0]        disp_q, disp_d;
  logic [7:0]         lfsr;
  logic               stop, free0, unused_bits;
  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .en(tick), .q(lfsr));
`ifdef OBS_SPEEDUP_EN
  logic [26:0] per_q, per_d;
  assign period = per_q;
  assign unused_bits = ^lfsr[7:2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) per_q <= TICK_DIV;
    else per_q <= per_d;
`else
  assign period = TICK_DIV;
  assign unused_bits = ^{lfsr[7:2], MIN_DIV, DIV_STEP};
`endif
  assign stop  = presente inside {OFF, WLCM, CH};
  assign free0 = ~(top_q[0] | bot_q[0]);
  assign disp_d = {slot_seg(top_q[0], bot_q[0]), slot_seg(top_q[1], bot_q[1]), slot_seg(top_q[2], bot_q[2])};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    bot_d   = bot_q;
    score_d = score_q;
    go_d    = go_q;
    hit_d   = 1'b0;
    tick    = 1'b0;
    inc     = 1'b0;
`ifdef OBS_SPEEDUP_EN
    per_d   = per_q;
`endif
    case (state_q)
      IDLE: begin
        if (presente == GAME) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop || presente == WL) state_d = IDLE;
        else if (presente != PA) begin
          tick  = cnt_q == period - 27'd1;
          cnt_d = tick ? '0 : cnt_q + 27'd1;
          if (tick && (hero_lane ? bot_q[2] : top_q[2])) begin
            state_d = HIT;
            hit_d   = 1'b1;
            go_d    = 1'b1;
          end else if (tick) begin
            // The spawn is suppressed behind an occupied slot0 so obstacles are always separated by a gap.
            top_d   = {top_q[1:0], free0 & (lfsr[1:0] == SPAWN_TOP)};
            bot_d   = {bot_q[1:0], free0 & (lfsr[1:0] == SPAWN_BOT)};
            inc     = (top_q[2] | bot_q[2]) & ~&score_q;
            score_d = inc ? score_q + SCORE_W'(1) : score_q;
          end
        end
      end
      HIT: state_d = stop ? IDLE : HIT;
      default: state_d = IDLE;
    endcase
`ifdef OBS_SPEEDUP_EN
    if (inc && score_d[2:0] == 3'd0) per_d = (per_q >= MIN_DIV + DIV_STEP) ? per_q - DIV_STEP : MIN_DIV;
`endif
    if (state_d == IDLE) begin
      cnt_d   = '0;
      top_d   = '0;
      bot_d   = '0;
      score_d = '0;
      go_d    = 1'b0;
`ifdef OBS_SPEEDUP_EN
      per_d   = TICK_DIV;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      score_q <= '0;
      go_q    <= 1'b0;
      hit_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      score_q <= score_d;
      go_q    <= go_d;
      hit_q   <= hit_d;
      disp_q  <= disp_d;
    end
  assign display_obs = disp_q;
  assign hit         = hit_q;
  assign game_over   = go_q;
  assign score       = score_q;
endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Generates the scrolling obstacle field for the GAME state and drives display_obs[20:0] into the 8-digit display multiplexer.
- Moves obstacles on two lanes across three small digits toward the hero digit, detects collisions and counts cleared obstacles.
- Sits between the top-level game state machine (source of presente) and the display block; hit and game_over go back to the state machine.

Parameters:
- TICK_DIV, 27'd6_000_000: clk cycles per scroll step.
- LFSR_SEED, 8'hA5: non-zero reset value of the spawn LFSR.
- SCORE_W, 8: score counter width.
- MIN_DIV, 27'd1_500_000: lowest TICK_DIV reachable with OBS_SPEEDUP_EN.
- DIV_STEP, 27'd500_000: period decrement with OBS_SPEEDUP_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- presente  in  3  game state code: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5
- hero_lane  in  1  hero lane: 0=top, 1=bottom
- display_obs  out  21  segments, active-high, bit0=a..bit6=g; [20:14] is the far digit, [6:0] is the digit next to the hero
- hit  out  1  one-cycle pulse on collision
- game_over  out  1  level; high from collision until the field is cleared
- score  out  SCORE_W  obstacles cleared, saturating

Behaviour:
- Reset values: display_obs=0, hit=0, game_over=0, score=0, slots empty, tick counter=0, LFSR=LFSR_SEED, FSM=IDLE.
- Field storage: top[2:0] and bot[2:0]; index 0 is the far digit.
- Slot encoding: a top obstacle sets segment a (bit0) of that digit; a bottom obstacle sets segment d (bit3). display_obs is registered, so it shows the field one cycle after any field update.
- IDLE:
  - Field, score and counter are held at 0.
  - presente==GAME moves to RUN and clears the tick counter.
- RUN:
  - The tick counter increments each cycle and wraps at TICK_DIV-1, producing a one-cycle tick.
  - presente==PA freezes the counter and the field; state remains RUN.
  - presente==OFF, WLCM or CH goes to IDLE and clears everything.
  - presente==WL while running also goes to IDLE.
- Tick in RUN:
  - Collision check first. If (hero_lane ? bot[2] : top[2]) is set: go to HIT, pulse hit the next cycle, set game_over, no shift.
  - Otherwise shift: slot2<=slot1, slot1<=slot0. Score +1 (saturating at all ones) if old slot2 was occupied.
  - New slot0 from LFSR[1:0]: 01 gives top, 10 gives bottom, 00 or 11 gives empty.
  - Spawn is forced empty if old slot0 was occupied, which guarantees a gap of at least one digit.
  - A slot never holds both lanes.
  - The LFSR advances one step per tick only. Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, shift left with feedback into bit0.
- HIT:
  - Field, score and game_over are held; display keeps showing the collision.
  - presente==OFF, WLCM or CH goes to IDLE and clears.
  - GAME, WL and PA all hold in HIT.
- hero_lane is sampled only at the tick; lane changes between ticks never cause a hit.
- Reset mid-game returns to IDLE immediately; the LFSR also reseeds.

Optional Feature:
- OBS_SPEEDUP_EN defined:
  - The active period register starts at TICK_DIV.
  - Every 8 cleared obstacles (score[2:0] wraps to 0) the period is reduced by DIV_STEP, floored at MIN_DIV.
  - The period resets to TICK_DIV on entering IDLE.
- Undefined: the period is the constant TICK_DIV and no period register exists.

Decomposition:
- heroe_pkg holds:
  - State codes OFF..PA.
  - Scroller FSM encoding IDLE=0, RUN=1, HIT=2.
  - Segment masks SEG_TOP=7'b0000001 and SEG_BOT=7'b0001000.
  - Spawn codes.
- One sub-module, lfsr8: clk, rst_n, en, seed parameter, q[7:0].

Test Plan (TICK_DIV=4, LFSR forced via seed where noted):
- Reset asserted mid-RUN with field occupied -> display_obs=0, score=0, game_over=0 in the same cycle, FSM IDLE.
- presente=GAME, seed chosen so the first spawn is top -> display_obs[20:14]=7'h01 after tick 1; 7'h01 reaches [6:0] after tick 3; first tick is 4 cycles after entering RUN.
- Top obstacle in slot2, hero_lane=1, tick -> shift occurs, score 0->1, hit stays 0.
- Top obstacle in slot2, hero_lane=0, tick -> hit high exactly 1 cycle, game_over=1, field frozen through presente=WL, cleared after presente=WLCM.
- presente=PA for 20 cycles mid-RUN -> display_obs and counter unchanged; resuming GAME continues from the same count.
- Score preloaded to 8'hFF, obstacle cleared -> score stays 8'hFF.
- With OBS_SPEEDUP_EN: 8 clears -> tick spacing drops by DIV_STEP; never below MIN_DIV.
